// File: rtl/lcd_char_writer.sv
// -----------------------------------------------------------------------------
// lcd_char_writer
//
// This block receives the character-message stream (lcd_data_in /
// lcd_enable_in) from the message generators. It buffers incoming ASCII bytes
// in a small FIFO and runs the HD44780-compatible power-up initialisation. It
// then writes each byte to a 16x2 character LCD using an 8-bit bus and correct
// E-strobe timing.
//
// When the cursor reaches the end of line 1, the block issues a 0xC0 command
// (line 2 home). When the cursor reaches the end of line 2, it issues a 0x80
// command (line 1 home). These commands are sent even if no further data is
// waiting.
//
// Optional feature (macro LCD_CLEAR_CHAR_EN):
//   defined   - a popped 0x0C (form feed) is not written as data. It becomes a
//               clear-display command (0x01) with the long clear settle time,
//               and the column counter restarts at 0.
//   undefined - 0x0C is written to the display like any other data byte.
//
// Ports:
//   clk            system clock
//   reset_not      asynchronous active-low reset
//   lcd_data_in    ASCII byte from the message generator
//   lcd_enable_in  byte valid; accepted on a rising edge while in_ready=1
//   in_ready       FIFO not full (combinational from the registered count)
//   lcd_rs         register select (0 = command, 1 = data)
//   lcd_rw         read/write, permanently 0 (write-only)
//   lcd_e          enable strobe
//   lcd_db         8-bit LCD data bus
//   busy           init running, write in progress, wrap pending or FIFO
//                  non-empty
//   overflow       sticky: a byte arrived while the FIFO was full
// -----------------------------------------------------------------------------
module lcd_char_writer #(
  parameter int INIT_WAIT_CYCLES = 750000,
  parameter int E_PULSE_CYCLES   = 25,
  parameter int SETTLE_CYCLES    = 2000,
  parameter int CLEAR_CYCLES     = 82000,
  parameter int FIFO_DEPTH       = 4,
  parameter int LINE_LEN         = 16
) (
  input  logic       clk,
  input  logic       reset_not,
  input  logic [7:0] lcd_data_in,
  input  logic       lcd_enable_in,
  output logic       in_ready,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       busy,
  output logic       overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  // The column counter must be able to hold 2*LINE_LEN for one cycle. This
  // lets the end-of-line-2 comparison be made before the counter wraps.
  localparam int COL_W = $clog2(2 * LINE_LEN + 1);

  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [COL_W-1:0] COL_LINE_END  = COL_W'(LINE_LEN);
  localparam logic [COL_W-1:0] COL_PAGE_END  = COL_W'(2 * LINE_LEN);

  localparam logic [31:0] INIT_WAIT_LAST = 32'(INIT_WAIT_CYCLES - 1);
  localparam logic [31:0] E_PULSE_LAST   = 32'(E_PULSE_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST    = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] CLEAR_LAST     = 32'(CLEAR_CYCLES - 1);

  localparam logic [7:0] CMD_FUNC_SET  = 8'h38;  // 8-bit bus, 2 lines, 5x8
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR     = 8'h01;  // clear display, home
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_LINE2     = 8'hC0;  // DDRAM address 0x40
  localparam logic [7:0] CMD_LINE1     = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] CHAR_FF       = 8'h0C;  // ASCII form feed

  // FSM state encoding
  localparam logic [2:0] ST_INIT_WAIT = 3'd0;
  localparam logic [2:0] ST_INIT_CMD  = 3'd1;
  localparam logic [2:0] ST_IDLE      = 3'd2;
  localparam logic [2:0] ST_SETUP     = 3'd3;
  localparam logic [2:0] ST_PULSE     = 3'd4;
  localparam logic [2:0] ST_HOLD      = 3'd5;

  // Initialisation command ROM
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = CMD_FUNC_SET;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_CLEAR;
      default: cmd = CMD_ENTRY_INC;
    endcase
    return cmd;
  endfunction

  // Last HOLD count for the byte on the bus. Only a clear *command* needs the
  // long settle time. A data byte of 0x01 is an ordinary CGRAM character.
  function automatic logic [31:0] hold_last(input logic rs, input logic [7:0] db);
    return (!rs && (db == CMD_CLEAR)) ? CLEAR_LAST : SETTLE_LAST;
  endfunction

  logic [2:0]       state;
  logic [31:0]      timer;
  logic [1:0]       init_idx;
  logic             init_done;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_inc;
  logic             wrap_pend;
  logic [7:0]       wrap_cmd;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [7:0]       head_byte;
  logic             head_is_clear;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  assign fifo_full  = (fifo_count == FIFO_FULL_CNT);
  assign fifo_empty = (fifo_count == '0);
  assign in_ready   = !fifo_full;
  assign push       = lcd_enable_in && !fifo_full;
  // A pending wrap command always goes out before the next data byte.
  assign pop        = (state == ST_IDLE) && !wrap_pend && !fifo_empty;
  assign head_byte  = fifo_mem[rd_ptr];

`ifdef LCD_CLEAR_CHAR_EN
  assign head_is_clear = (head_byte == CHAR_FF);
`else
  assign head_is_clear = 1'b0;
`endif

  // Storage needs no reset. Only the pointers and count define which entries
  // are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= lcd_data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // in_ready comes from the registered count, so a pop only frees a slot
      // from the following cycle onward.
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (lcd_enable_in && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write sequencer
  // ---------------------------------------------------------------------------
  assign col_inc = col + 1'b1;

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      state     <= ST_INIT_WAIT;
      timer     <= '0;
      init_idx  <= '0;
      init_done <= 1'b0;
      col       <= '0;
      wrap_pend <= 1'b0;
      wrap_cmd  <= '0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_db    <= '0;
    end else begin
      case (state)
        ST_INIT_WAIT: begin
          if (timer == INIT_WAIT_LAST) begin
            timer <= '0;
            state <= ST_INIT_CMD;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_INIT_CMD: begin
          lcd_db <= init_cmd(init_idx);
          lcd_rs <= 1'b0;
          state  <= ST_SETUP;
        end

        ST_IDLE: begin
          if (wrap_pend) begin
            lcd_db    <= wrap_cmd;
            lcd_rs    <= 1'b0;
            wrap_pend <= 1'b0;
            state     <= ST_SETUP;
          end else if (!fifo_empty) begin
            state <= ST_SETUP;
            if (head_is_clear) begin
              lcd_db <= CMD_CLEAR;
              lcd_rs <= 1'b0;
              col    <= '0;
            end else begin
              lcd_db <= head_byte;
              lcd_rs <= 1'b1;
              // The column is advanced as the byte is launched. Any wrap
              // command it causes is then queued for the next IDLE visit.
              if (col_inc == COL_LINE_END) begin
                wrap_pend <= 1'b1;
                wrap_cmd  <= CMD_LINE2;
                col       <= col_inc;
              end else if (col_inc == COL_PAGE_END) begin
                wrap_pend <= 1'b1;
                wrap_cmd  <= CMD_LINE1;
                col       <= '0;
              end else begin
                col <= col_inc;
              end
            end
          end
        end

        // lcd_db/lcd_rs are already valid here and stay untouched through HOLD.
        ST_SETUP: begin
          lcd_e <= 1'b1;
          timer <= '0;
          state <= ST_PULSE;
        end

        ST_PULSE: begin
          if (timer == E_PULSE_LAST) begin
            lcd_e <= 1'b0;
            timer <= '0;
            state <= ST_HOLD;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_HOLD: begin
          if (timer == hold_last(lcd_rs, lcd_db)) begin
            timer <= '0;
            if (init_done) begin
              state <= ST_IDLE;
            end else if (init_idx == 2'd3) begin
              init_done <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              init_idx <= init_idx + 1'b1;
              state    <= ST_INIT_CMD;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          lcd_e <= 1'b0;
          timer <= '0;
          state <= ST_INIT_WAIT;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign lcd_rw = 1'b0;
  assign busy   = (state != ST_IDLE) || !fifo_empty || wrap_pend;

endmodule

// File: tb/tb_lcd_char_writer.sv
// -----------------------------------------------------------------------------
// tb_lcd_char_writer
//
// Scoreboard bench for lcd_char_writer.
//
// The stimulus side pushes the hand-computed {rs, db} pair for every LCD write
// it expects. A forked monitor watches lcd_e. On each rising strobe, the
// monitor pops the next expected pair and compares it with the bus. It also
// checks the pulse width, that the bus stays stable until the strobe falls,
// and the settle gap before the next strobe.
//
// Build with +define+LCD_CLEAR_CHAR_EN to exercise the form-feed clear option.
// -----------------------------------------------------------------------------
module tb_lcd_char_writer;

  localparam int INIT_WAIT = 10;
  localparam int E_PULSE   = 2;
  localparam int SETTLE    = 4;
  localparam int CLEARC    = 8;
  localparam int DEPTH     = 4;
  localparam int LINE      = 4;

  logic       clk = 1'b0;
  logic       reset_not;
  logic [7:0] lcd_data_in;
  logic       lcd_enable_in;
  logic       in_ready;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;
  logic       busy;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] sb[$];

  lcd_char_writer #(
    .INIT_WAIT_CYCLES(INIT_WAIT),
    .E_PULSE_CYCLES  (E_PULSE),
    .SETTLE_CYCLES   (SETTLE),
    .CLEAR_CYCLES    (CLEARC),
    .FIFO_DEPTH      (DEPTH),
    .LINE_LEN        (LINE)
  ) dut (
    .clk          (clk),
    .reset_not    (reset_not),
    .lcd_data_in  (lcd_data_in),
    .lcd_enable_in(lcd_enable_in),
    .in_ready     (in_ready),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_e        (lcd_e),
    .lcd_db       (lcd_db),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_q(input logic rs, input logic [7:0] db);
    sb.push_back({rs, db});
  endtask

  task automatic exp_init();
    exp_q(1'b0, 8'h38);
    exp_q(1'b0, 8'h0C);
    exp_q(1'b0, 8'h01);
    exp_q(1'b0, 8'h06);
  endtask

  task automatic push_one(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(in_ready), 32'd1);
    lcd_data_in   = b;
    lcd_enable_in = 1'b1;
    @(negedge clk);
    lcd_enable_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || busy) && n < 2000);
    chk({name, "_drained"}, 32'(sb.size() == 0 && !busy), 32'd1);
  endtask

  // Strobe monitor; forked from the main initial block
  task automatic monitor();
    logic       prev_e;
    logic       have_fall;
    logic       first;
    int         hi;
    int         lo;
    int         since_rst;
    logic [8:0] cur;
    logic [8:0] last;
    logic [8:0] e;
    prev_e = 1'b0; have_fall = 1'b0; first = 1'b1;
    hi = 0; lo = 0; since_rst = 0; cur = '0; last = '0;
    forever begin
      @(negedge clk);
      if (!reset_not) begin
        prev_e = 1'b0; have_fall = 1'b0; first = 1'b1;
        hi = 0; lo = 0; since_rst = 0;
      end else begin
        since_rst++;
        if (lcd_e && !prev_e) begin
          if (first) chk("init_wait_len", 32'(since_rst >= INIT_WAIT), 32'd1);
          first = 1'b0;
          if (have_fall) begin
            if (last == {1'b0, 8'h01}) chk("clear_gap", 32'(lo >= CLEARC), 32'd1);
            else                       chk("settle_gap", 32'(lo >= SETTLE), 32'd1);
          end
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: got rs=%0d db=%02h, required no strobe (t=%0t)",
                     lcd_rs, lcd_db, $time);
          end else begin
            e = sb.pop_front();
            chk("strobe_rs", 32'(lcd_rs), 32'(e[8]));
            chk("strobe_db", 32'(lcd_db), 32'(e[7:0]));
          end
          cur = {lcd_rs, lcd_db};
          hi  = 1;
        end else if (lcd_e) begin
          hi++;
        end else if (prev_e) begin
          chk("pulse_width", 32'(hi), 32'(E_PULSE));
          chk("bus_stable", 32'({lcd_rs, lcd_db}), 32'(cur));
          last      = cur;
          lo        = 1;
          have_fall = 1'b1;
        end else begin
          lo++;
        end
        prev_e = lcd_e;
      end
    end
  endtask

  initial begin
    int n;
    reset_not     = 1'b0;
    lcd_enable_in = 1'b0;
    lcd_data_in   = 8'h00;
    fork
      monitor();
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_e", 32'(lcd_e), 32'd0);
    chk("rst_rs", 32'(lcd_rs), 32'd0);
    chk("rst_rw", 32'(lcd_rw), 32'd0);
    chk("rst_db", 32'(lcd_db), 32'h00);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Power-up init with no input
    exp_init();
    @(negedge clk);
    reset_not = 1'b1;
    wait_idle("init");
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_overflow", 32'(overflow), 32'd0);

    // "Fail" on consecutive cycles; line 1 fills and a 0xC0 follows
    exp_q(1'b1, 8'h46); exp_q(1'b1, 8'h61); exp_q(1'b1, 8'h69); exp_q(1'b1, 8'h6C);
    exp_q(1'b0, 8'hC0);
    @(negedge clk); lcd_data_in = 8'h46; lcd_enable_in = 1'b1;
    @(negedge clk); lcd_data_in = 8'h61;
    @(negedge clk); lcd_data_in = 8'h69;
    @(negedge clk); lcd_data_in = 8'h6C;
    @(negedge clk); lcd_enable_in = 1'b0;
    wait_idle("fail_msg");
    chk("fail_msg_busy", 32'(busy), 32'd0);

    // Reset asserted while lcd_e is high
    exp_q(1'b1, 8'h41);
    push_one(8'h41);
    push_one(8'h42);
    n = 0;
    while (!lcd_e && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("e_seen_before_reset", 32'(lcd_e), 32'd1);
    #1 reset_not = 1'b0;
    #1;
    chk("async_rst_e", 32'(lcd_e), 32'd0);
    chk("async_rst_db", 32'(lcd_db), 32'h00);
    chk("async_rst_rs", 32'(lcd_rs), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd1);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    chk("async_rst_overflow", 32'(overflow), 32'd0);

    // Overflow during init: 6 cycles of enable, only 4 accepted
    exp_init();
    exp_q(1'b1, 8'h31); exp_q(1'b1, 8'h32); exp_q(1'b1, 8'h33); exp_q(1'b1, 8'h34);
    exp_q(1'b0, 8'hC0);
    reset_not = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      lcd_data_in   = 8'(8'h30 + k);
      lcd_enable_in = 1'b1;
      #1;
      chk($sformatf("ovf_in_ready_%0d", k), 32'(in_ready), (k <= 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    lcd_enable_in = 1'b0;
    #1;
    chk("ovf_set", 32'(overflow), 32'd1);
    wait_idle("ovf");
    chk("ovf_latched", 32'(overflow), 32'd1);

    // Clean restart, then 8 bytes: 0xC0 after the 4th, 0x80 after the 8th
    @(negedge clk);
    reset_not = 1'b0;
    @(negedge clk);
    #1 chk("rst2_overflow", 32'(overflow), 32'd0);
    exp_init();
    reset_not = 1'b1;
    wait_idle("reinit");
    for (int k = 0; k < 8; k++) begin
      exp_q(1'b1, 8'(8'h61 + k));
      if (k == 3) exp_q(1'b0, 8'hC0);
      if (k == 7) exp_q(1'b0, 8'h80);
    end
    for (int k = 0; k < 8; k++) push_one(8'(8'h61 + k));
    wait_idle("two_lines");

    // Form feed handling. The column is 0 here, so the position of the 0xC0
    // shows whether the form feed reset the column.
`ifdef LCD_CLEAR_CHAR_EN
    exp_q(1'b1, 8'h41); exp_q(1'b0, 8'h01); exp_q(1'b1, 8'h42);
    exp_q(1'b1, 8'h78); exp_q(1'b1, 8'h79); exp_q(1'b1, 8'h7A);
    exp_q(1'b0, 8'hC0);
`else
    exp_q(1'b1, 8'h41); exp_q(1'b1, 8'h0C); exp_q(1'b1, 8'h42);
    exp_q(1'b1, 8'h78); exp_q(1'b0, 8'hC0);
    exp_q(1'b1, 8'h79); exp_q(1'b1, 8'h7A);
`endif
    push_one(8'h41);
    push_one(8'h0C);
    push_one(8'h42);
    push_one(8'h78);
    push_one(8'h79);
    push_one(8'h7A);
    wait_idle("form_feed");
    chk("final_rw", 32'(lcd_rw), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
